// File: rtl/wb_out_queue.sv
// wb_out_queue
// Writeback-side egress for the vector register file. Writes aimed at
// register address 0 are diverted into a small show-ahead queue that an
// external consumer drains with a valid/ready handshake. All other writes
// pass straight through to the register-file write port.
//
// Ports:
//   clk, rstn            clock (posedge) and asynchronous active-low reset
//   wec, addrc, wdata_c  write request from execute (per-lane enables)
//   rf_wec, rf_addrc,
//   rf_wdata             register-file write port (combinational passthrough)
//   stall                queue full; the pipeline must hold address-0 writes
//   flush                synchronous queue clear (keeps the overflow flag)
//   out_valid, out_ready,
//   out_data, out_mask   head of the queue and its consumer handshake
//   count                queue occupancy, 0..2**WA_FIFO
//   overflow             sticky flag: an address-0 write was dropped while full
module wb_out_queue #(
  parameter int WIDTH_ADDR   = 4,
  parameter int WIDTH_VECTOR = 8,
  parameter int N            = 32,
  parameter int WA_FIFO      = 3
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [WIDTH_VECTOR-1:0]             wec,
  input  logic [WIDTH_ADDR-1:0]               addrc,
  input  logic [WIDTH_VECTOR-1:0][N-1:0]      wdata_c,
  output logic [WIDTH_VECTOR-1:0]             rf_wec,
  output logic [WIDTH_ADDR-1:0]               rf_addrc,
  output logic [WIDTH_VECTOR-1:0][N-1:0]      rf_wdata,
  output logic                                stall,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH_VECTOR-1:0][N-1:0]      out_data,
  output logic [WIDTH_VECTOR-1:0]             out_mask,
  output logic [WA_FIFO:0]                    count,
  output logic                                overflow
);

  localparam int                  DEPTH     = 2 ** WA_FIFO;
  localparam logic [WA_FIFO:0]    CNT_FULL  = (WA_FIFO+1)'(DEPTH);
  localparam logic [WA_FIFO:0]    CNT_ONE   = (WA_FIFO+1)'(1);
  localparam logic [WA_FIFO-1:0]  PTR_ONE   = WA_FIFO'(1);

  logic [WIDTH_VECTOR-1:0][N-1:0] data_mem [DEPTH];
  logic [WIDTH_VECTOR-1:0]        mask_mem [DEPTH];

  logic [WA_FIFO-1:0] wptr_q, wptr_d;
  logic [WA_FIFO-1:0] rptr_q, rptr_d;
  logic [WA_FIFO:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic                           push_req;
  logic                           push_ok;
  logic                           pop;
  logic                           full;
  logic [WIDTH_VECTOR-1:0][N-1:0] masked_data;

  // Register-file passthrough: address-0 writes are suppressed here because
  // they go to the queue instead.
  always_comb begin
    rf_addrc = addrc;
    rf_wdata = wdata_c;
    rf_wec   = (addrc != '0) ? wec : '0;
  end

  // Lanes that are not enabled store zero so the consumer never sees stale data.
  always_comb begin
    masked_data = '0;
    for (int i = 0; i < WIDTH_VECTOR; i++) begin
      masked_data[i] = wec[i] ? wdata_c[i] : '0;
    end
  end

  always_comb begin
    full      = (count_q == CNT_FULL);
    out_valid = (count_q != '0);
    pop       = out_valid && out_ready;
    push_req  = (addrc == '0) && (|wec);
    // A full queue still takes a push when the head leaves in the same cycle.
    push_ok   = push_req && (!full || pop) && !flush;
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PTR_ONE;
      if (pop)     rptr_d = rptr_q + PTR_ONE;
      if (push_ok && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push_ok) count_d = count_q - CNT_ONE;
      if (push_req && full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; the empty case is masked at the head.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      data_mem[wptr_q] <= masked_data;
      mask_mem[wptr_q] <= wec;
    end
  end

  always_comb begin
    out_data = out_valid ? data_mem[rptr_q] : '0;
    out_mask = out_valid ? mask_mem[rptr_q] : '0;
    stall    = full;
    count    = count_q;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_wb_out_queue.sv
module tb_wb_out_queue;

  typedef logic [7:0][31:0] vec_t;

  logic       clk;
  logic       rstn;
  logic [7:0] wec;
  logic [3:0] addrc;
  vec_t       wdata_c;
  logic [7:0] rf_wec;
  logic [3:0] rf_addrc;
  vec_t       rf_wdata;
  logic       stall;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  vec_t       out_data;
  logic [7:0] out_mask;
  logic [3:0] count;
  logic       overflow;

  int checkCount;
  int failCount;

  wb_out_queue dut (
    .clk       (clk),
    .rstn      (rstn),
    .wec       (wec),
    .addrc     (addrc),
    .wdata_c   (wdata_c),
    .rf_wec    (rf_wec),
    .rf_addrc  (rf_addrc),
    .rf_wdata  (rf_wdata),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane i holds base + i.
  function automatic vec_t mkLanes(input logic [31:0] base);
    vec_t v;
    for (int i = 0; i < 8; i++) v[i] = base + 32'(i);
    return v;
  endfunction

  // Entry tagged k carries lanes (k << 8) + i, all lanes enabled.
  function automatic vec_t tagLanes(input int tag);
    return mkLanes(32'(tag) << 8);
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [7:0] w,
                               input vec_t d, input logic rdy, input logic fl);
    addrc     = a;
    wec       = w;
    wdata_c   = d;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Advance one clock; inputs and checks happen 1 time unit after the edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    applyStimulus(4'd1, 8'h00, '0, 1'b0, 1'b0);
  endtask

  initial begin
    vec_t expData;
    checkCount = 0;
    failCount  = 0;
    rstn = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_count", 256'(count), 256'd0);
    checkOutput("rst_valid", 256'(out_valid), 256'd0);
    checkOutput("rst_stall", 256'(stall), 256'd0);
    checkOutput("rst_overflow", 256'(overflow), 256'd0);
    checkOutput("rst_data", 256'(out_data), 256'd0);
    checkOutput("rst_mask", 256'(out_mask), 256'd0);

    $display("[TB] passthrough");
    applyStimulus(4'd5, 8'hFF, mkLanes(32'd1), 1'b0, 1'b0);
    #1;
    checkOutput("pt_wec", 256'(rf_wec), 256'hFF);
    checkOutput("pt_addr", 256'(rf_addrc), 256'd5);
    checkOutput("pt_wdata", 256'(rf_wdata), 256'(mkLanes(32'd1)));
    stepCycle();
    idleInputs();
    checkOutput("pt_count", 256'(count), 256'd0);
    checkOutput("pt_valid", 256'(out_valid), 256'd0);

    $display("[TB] single push");
    applyStimulus(4'd0, 8'h0F, mkLanes(32'hA0), 1'b0, 1'b0);
    #1;
    checkOutput("sp_rfwec", 256'(rf_wec), 256'd0);
    checkOutput("sp_valid_before", 256'(out_valid), 256'd0);
    stepCycle();
    idleInputs();
    expData = '0;
    for (int i = 0; i < 4; i++) expData[i] = 32'hA0 + 32'(i);
    checkOutput("sp_valid", 256'(out_valid), 256'd1);
    checkOutput("sp_mask", 256'(out_mask), 256'h0F);
    checkOutput("sp_data", 256'(out_data), 256'(expData));
    checkOutput("sp_count", 256'(count), 256'd1);
    applyStimulus(4'd1, 8'h00, '0, 1'b1, 1'b0);
    stepCycle();
    idleInputs();
    checkOutput("sp_count_after", 256'(count), 256'd0);
    checkOutput("sp_valid_after", 256'(out_valid), 256'd0);
    checkOutput("sp_data_empty", 256'(out_data), 256'd0);

    $display("[TB] fill and wrap");
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(4'd0, 8'hFF, tagLanes(k), 1'b0, 1'b0);
      stepCycle();
    end
    idleInputs();
    checkOutput("fill_count", 256'(count), 256'd8);
    checkOutput("fill_stall", 256'(stall), 256'd1);
    for (int k = 1; k <= 3; k++) begin
      checkOutput($sformatf("pop_head%0d", k), 256'(out_data), 256'(tagLanes(k)));
      applyStimulus(4'd1, 8'h00, '0, 1'b1, 1'b0);
      stepCycle();
    end
    idleInputs();
    checkOutput("pop3_count", 256'(count), 256'd5);
    checkOutput("pop3_stall", 256'(stall), 256'd0);
    for (int k = 9; k <= 11; k++) begin
      applyStimulus(4'd0, 8'hFF, tagLanes(k), 1'b0, 1'b0);
      stepCycle();
    end
    idleInputs();
    checkOutput("wrap_count", 256'(count), 256'd8);
    checkOutput("wrap_head", 256'(out_data), 256'(tagLanes(4)));

    $display("[TB] full with simultaneous ops");
    applyStimulus(4'd0, 8'hFF, tagLanes(12), 1'b1, 1'b0);
    stepCycle();
    idleInputs();
    checkOutput("fullpp_count", 256'(count), 256'd8);
    checkOutput("fullpp_overflow", 256'(overflow), 256'd0);
    checkOutput("fullpp_head", 256'(out_data), 256'(tagLanes(5)));
    applyStimulus(4'd0, 8'hFF, tagLanes(13), 1'b0, 1'b0);
    stepCycle();
    idleInputs();
    checkOutput("drop_count", 256'(count), 256'd8);
    checkOutput("drop_overflow", 256'(overflow), 256'd1);
    checkOutput("drop_head", 256'(out_data), 256'(tagLanes(5)));
    for (int k = 5; k <= 12; k++) begin
      checkOutput($sformatf("drain_head%0d", k), 256'(out_data), 256'(tagLanes(k)));
      applyStimulus(4'd1, 8'h00, '0, 1'b1, 1'b0);
      stepCycle();
    end
    idleInputs();
    checkOutput("drain_count", 256'(count), 256'd0);
    checkOutput("drain_overflow", 256'(overflow), 256'd1);

    $display("[TB] flush");
    for (int k = 20; k <= 24; k++) begin
      applyStimulus(4'd0, 8'hFF, tagLanes(k), 1'b0, 1'b0);
      stepCycle();
    end
    checkOutput("fl_count_before", 256'(count), 256'd5);
    applyStimulus(4'd0, 8'hFF, tagLanes(25), 1'b1, 1'b1);
    stepCycle();
    idleInputs();
    checkOutput("fl_count", 256'(count), 256'd0);
    checkOutput("fl_valid", 256'(out_valid), 256'd0);
    checkOutput("fl_overflow", 256'(overflow), 256'd1);
    checkOutput("fl_stall", 256'(stall), 256'd0);

    $display("[TB] reset mid-stream");
    for (int k = 30; k <= 33; k++) begin
      applyStimulus(4'd0, 8'hFF, tagLanes(k), 1'b0, 1'b0);
      stepCycle();
    end
    idleInputs();
    checkOutput("mr_count_before", 256'(count), 256'd4);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("mr_count", 256'(count), 256'd0);
    checkOutput("mr_valid", 256'(out_valid), 256'd0);
    checkOutput("mr_stall", 256'(stall), 256'd0);
    checkOutput("mr_overflow", 256'(overflow), 256'd0);
    #2;
    rstn = 1'b1;
    applyStimulus(4'd0, 8'hFF, tagLanes(40), 1'b0, 1'b0);
    #1;
    checkOutput("mr_push_valid_before", 256'(out_valid), 256'd0);
    stepCycle();
    idleInputs();
    checkOutput("mr_push_valid", 256'(out_valid), 256'd1);
    checkOutput("mr_push_head", 256'(out_data), 256'(tagLanes(40)));
    checkOutput("mr_push_count", 256'(count), 256'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/wb_out_queue.md
Name: wb_out_queue

Overview:
- Writeback-side egress for the vector register file; the write-path counterpart of the operand input FIFO mapped at register address 0.
- Writes from execute with `addrc == 0` are not sent to the register file. They are enqueued into a synchronous output queue, which an external consumer drains through a valid/ready handshake.
- Writes with `addrc != 0` pass through unchanged to the register-file write port.
- Provides stall back-pressure to the pipeline and a sticky overflow error.

Parameters:
- WIDTH_ADDR, 4: register address width.
- WIDTH_VECTOR, 8: number of lanes.
- N, 32: lane data width.
- WA_FIFO, 3: queue address width; depth D = 2**WA_FIFO.

Ports:
- clk  input  1  clock; all logic on posedge.
- rstn  input  1  asynchronous active-low reset.
- wec  input  WIDTH_VECTOR  per-lane write enable from execute.
- addrc  input  WIDTH_ADDR  destination register address.
- wdata_c  input  WIDTH_VECTOR*N  write data, packed as [WIDTH_VECTOR-1:0][N-1:0].
- rf_wec  output  WIDTH_VECTOR  lane enables to register file.
- rf_addrc  output  WIDTH_ADDR  address to register file.
- rf_wdata  output  WIDTH_VECTOR*N  data to register file.
- stall  output  1  queue full; pipeline must hold addr-0 writes.
- flush  input  1  synchronous queue clear.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head.
- out_data  output  WIDTH_VECTOR*N  head data.
- out_mask  output  WIDTH_VECTOR  head lane mask (captured wec).
- count  output  WA_FIFO+1  occupancy, 0..D.
- overflow  output  1  sticky: a push was dropped.

Behaviour:
- Reset (rstn low, asynchronous):
  - wptr = 0, rptr = 0, count = 0, overflow = 0.
  - out_valid = 0, stall = 0.
  - out_data and out_mask read as 0 when empty.
  - Storage contents are not reset.
- Passthrough (combinational, 0 latency):
  - rf_addrc = addrc.
  - rf_wdata = wdata_c.
  - rf_wec = wec when addrc != 0, else all zeros.
- Push request: `push_req = (addrc == 0) && |wec`.
- Enqueue:
  - On push_req, store {wec, data} at wptr. Data is masked per lane: a lane with wec = 0 stores 0.
- Dequeue:
  - `pop = out_valid && out_ready`; rptr advances by 1.
- Head (show-ahead, combinational read of mem[rptr]):
  - out_valid = (count != 0).
  - out_data and out_mask come from mem[rptr]; both are 0 when count == 0.
- Latency: an entry pushed at edge t is visible on out_valid after edge t; there is no same-cycle bypass when empty.
- Pointers: WA_FIFO bits, natural wrap from D-1 to 0.
- count update, by case:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
- stall = (count == D), combinational from registered count.
- Full handling:
  - push_req while full with no simultaneous pop: the push is dropped, overflow is set to 1 (sticky until reset), and state is otherwise unchanged.
  - push_req while full with a simultaneous pop: the push is accepted and count stays D.
- Empty handling: pop cannot occur (out_valid = 0); out_ready is ignored.
- flush: sets wptr, rptr and count to 0 next edge.
  - Flush overrides any same-cycle push and pop.
  - Flush does not clear overflow.
- Reset mid-operation empties the queue immediately; the passthrough path stays combinational.

Test Plan:
1. Passthrough: addrc = 5, wec = 8'hFF, lane data = i+1 -> rf_wec = FF, rf_addrc = 5, count stays 0, out_valid = 0.
2. Single push: addrc = 0, wec = 8'h0F, lanes = 32'hA0+i -> rf_wec = 0; next cycle out_valid = 1, out_mask = 0F, lanes 0-3 = A0..A3, lanes 4-7 = 0; out_ready = 1 -> count returns to 0.
3. Fill and wrap: push 8 entries (tag 1..8) with out_ready = 0 -> count = 8, stall = 1. Then pop 3 and push 3 more (tag 9..11) -> pop order 4..11, pointer wrap exercised.
4. Full with simultaneous ops: at count = 8, push with out_ready = 1 -> count stays 8, overflow = 0. Push with out_ready = 0 -> push dropped, overflow = 1, head unchanged.
5. Flush: count = 5, flush together with push and pop -> count = 0 next cycle, out_valid = 0, overflow unchanged.
6. Reset mid-stream: count = 4 and rstn pulses low between edges -> count = 0, out_valid = 0, stall = 0 immediately. Post-reset push -> appears one cycle later.
